// File: rtl/dds_defs_pkg.sv
// Shared DDS definitions: width constants, signal type codes and the sequencer FSM encoding.
package dds_defs;

    localparam int SIGNAL_TYPE_BIT = 2;
    localparam int DAC_MAX_V_BIT   = 12;
    localparam int ROM_PHASE_BIT   = 16;
    localparam int OFFSET_BIT      = 12;

    typedef enum logic [1:0] {
        SINE     = 2'd0,
        SQUARE   = 2'd1,
        TRIANGLE = 2'd2
    } sig_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RAMP   = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/dds_cfg_sequencer.sv
// Shadows UART parameter sets and commits them to the DDS core on a phase wrap (or timeout).
// Optional amplitude ramping on wraps is enabled by defining DDS_AMP_RAMP_EN.
module dds_cfg_sequencer
    import dds_defs::*;
#(
    parameter int BN_ST     = SIGNAL_TYPE_BIT,
    parameter int BN_A      = DAC_MAX_V_BIT - 1,
    parameter int BN_F      = ROM_PHASE_BIT - 1,
    parameter int BN_O      = OFFSET_BIT,
    parameter int TYPE_MAX  = 2,
    parameter int TIMEOUT   = 1023,
    parameter int RAMP_STEP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_data_flag,
    input  logic [BN_ST-1:0] in_type,
    input  logic [BN_F-1:0]  in_frequency,
    input  logic [BN_O-1:0]  in_offset,
    input  logic [BN_A-1:0]  in_amplitude,
    input  logic             phase_wrap,
    output logic [BN_ST-1:0] sig_type,
    output logic [BN_F-1:0]  sig_frequency,
    output logic [BN_O-1:0]  sig_offset,
    output logic [BN_A-1:0]  sig_amplitude,
    output logic             cfg_update,
    output logic             busy,
    output logic             cfg_err
);

    localparam int          CW      = $clog2(TIMEOUT + 1);
    localparam logic [31:0] TO_LAST = TIMEOUT - 1;

    cfg_state_e       state;
    logic [CW-1:0]    cnt;
    logic [BN_ST-1:0] sh_type;
    logic [BN_F-1:0]  sh_frequency;
    logic [BN_O-1:0]  sh_offset;
    logic [BN_A-1:0]  sh_amplitude;
    logic             type_ok;
    logic             flag_ok;
    logic             to_hit;

    assign type_ok = {{(32-BN_ST){1'b0}}, in_type} <= $unsigned(TYPE_MAX);
    assign flag_ok = new_data_flag && type_ok;
    // Leave PEND on the edge where the counter would reach TIMEOUT-1.
    assign to_hit  = ({{(32-CW){1'b0}}, cnt} + 32'd1) >= TO_LAST;
    assign busy    = (state != ST_IDLE);

`ifdef DDS_AMP_RAMP_EN
    localparam logic [BN_A:0] STEP_W = RAMP_STEP[BN_A:0];
    logic [BN_A-1:0] amp_nxt;

    // One step toward the target, clamped so the target is never crossed.
    always_comb begin
        amp_nxt = sh_amplitude;
        if (sig_amplitude < sh_amplitude) begin
            if ({1'b0, sh_amplitude - sig_amplitude} > STEP_W)
                amp_nxt = sig_amplitude + STEP_W[BN_A-1:0];
        end else if ({1'b0, sig_amplitude - sh_amplitude} > STEP_W) begin
            amp_nxt = sig_amplitude - STEP_W[BN_A-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            sh_type       <= '0;
            sh_frequency  <= '0;
            sh_offset     <= '0;
            sh_amplitude  <= '0;
            sig_type      <= '0;
            sig_frequency <= '0;
            sig_offset    <= '0;
            sig_amplitude <= '0;
            cfg_update    <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            if (new_data_flag && !type_ok)
                cfg_err <= 1'b1;
            if (flag_ok) begin
                sh_type      <= in_type;
                sh_frequency <= in_frequency;
                sh_offset    <= in_offset;
                sh_amplitude <= in_amplitude;
            end

            case (state)
                ST_IDLE: begin
                    if (flag_ok)
                        state <= ST_PEND;
                end
                ST_PEND: begin
                    cnt <= cnt + CW'(1);
                    if (phase_wrap || to_hit)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    // Shadow is read before this edge's capture, so a flag here commits the old set.
                    sig_type      <= sh_type;
                    sig_frequency <= sh_frequency;
                    sig_offset    <= sh_offset;
                    cnt           <= '0;
                    cfg_update    <= 1'b1;
`ifdef DDS_AMP_RAMP_EN
                    state <= flag_ok ? ST_PEND : ST_RAMP;
`else
                    sig_amplitude <= sh_amplitude;
                    state <= flag_ok ? ST_PEND : ST_IDLE;
`endif
                end
                ST_RAMP: begin
`ifdef DDS_AMP_RAMP_EN
                    if (flag_ok) begin
                        state <= ST_PEND;
                    end else if (sig_amplitude == sh_amplitude) begin
                        state <= ST_IDLE;
                    end else if (phase_wrap) begin
                        sig_amplitude <= amp_nxt;
                        if (amp_nxt == sh_amplitude)
                            state <= ST_IDLE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
